// File: rtl/riscv_csr_trap_seq_if.sv
// Bundle between the pipeline, the trap/return sequencer and the machine CSR file.
// The sequencer side is the slave modport; the pipeline/CSR-file environment is the master.
interface riscv_csr_trap_seq_if #(
    parameter int WORD_LENGTH = 32
);
    // Requests are plain strobes sampled only in the accept cycle; busy is the
    // stall back to the pipeline and redirect_valid is a single-cycle strobe.
    logic                   trap_req;
    logic [WORD_LENGTH-1:0] trap_cause;
    logic [WORD_LENGTH-1:0] trap_pc;
    logic [WORD_LENGTH-1:0] trap_tval;
    logic                   mret_req;
    logic                   pipe_csr_wen;
    logic [11:0]            pipe_csr_addr;
    logic [WORD_LENGTH-1:0] pipe_csr_wdata;
    logic                   csr_wen;
    logic [11:0]            csr_addr;
    logic [WORD_LENGTH-1:0] csr_wdata;
    logic [WORD_LENGTH-1:0] csr_rdata;
    logic                   busy;
    logic                   redirect_valid;
    logic [WORD_LENGTH-1:0] redirect_pc;
    logic [3:0]             dbg_state;

    modport master (
        output trap_req, trap_cause, trap_pc, trap_tval, mret_req,
        output pipe_csr_wen, pipe_csr_addr, pipe_csr_wdata, csr_rdata,
        input  csr_wen, csr_addr, csr_wdata, busy, redirect_valid, redirect_pc, dbg_state
    );

    modport slave (
        input  trap_req, trap_cause, trap_pc, trap_tval, mret_req,
        input  pipe_csr_wen, pipe_csr_addr, pipe_csr_wdata, csr_rdata,
        output csr_wen, csr_addr, csr_wdata, busy, redirect_valid, redirect_pc, dbg_state
    );
endinterface

// File: rtl/riscv_csr_trap_seq.sv
// Trap-entry / MRET sequencer owning the single machine-CSR write port.
// One CSR access per state; issues a registered one-cycle PC redirect on completion.
module riscv_csr_trap_seq #(
    parameter int WORD_LENGTH = 32
) (
    input logic                 clk,
    input logic                 rst_n,
    riscv_csr_trap_seq_if.slave bus
);
    localparam logic [11:0] ADDR_MSTATUS = 12'h300;
    localparam logic [11:0] ADDR_MTVEC   = 12'h305;
    localparam logic [11:0] ADDR_MEPC    = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
    localparam logic [11:0] ADDR_MTVAL   = 12'h343;

    typedef enum logic [3:0] {
        IDLE, T_EPC, T_CAUSE, T_TVAL, T_SRD, T_SWR, T_VEC, M_SRD, M_SWR, M_EPC
    } state_e;

    state_e                 state_q, state_d;
    logic [WORD_LENGTH-1:0] cause_q, cause_d;
    logic [WORD_LENGTH-1:0] pc_q, pc_d;
    logic [WORD_LENGTH-1:0] tval_q, tval_d;
    logic [WORD_LENGTH-1:0] mstatus_q, mstatus_d;
    logic                   redirect_valid_q, redirect_valid_d;
    logic [WORD_LENGTH-1:0] redirect_pc_q, redirect_pc_d;

    logic                   wen_c;
    logic [11:0]            addr_c;
    logic [WORD_LENGTH-1:0] wdata_c;
    logic [WORD_LENGTH-1:0] mstatus_trap;
    logic [WORD_LENGTH-1:0] mstatus_mret;
    logic [WORD_LENGTH-1:0] vec_base;
    logic [WORD_LENGTH-1:0] vec_off;

    always_comb begin
        mstatus_trap        = mstatus_q;
        mstatus_trap[7]     = mstatus_q[3];
        mstatus_trap[3]     = 1'b0;
        mstatus_trap[12:11] = 2'b11;
        mstatus_mret        = mstatus_q;
        mstatus_mret[3]     = mstatus_q[7];
        mstatus_mret[7]     = 1'b1;
        mstatus_mret[12:11] = 2'b11;
        vec_base = {bus.csr_rdata[WORD_LENGTH-1:2], 2'b00};
        // Vector offset is (cause without MSB) << 2, wrapping at WORD_LENGTH.
        vec_off  = {cause_q[WORD_LENGTH-3:0], 2'b00};
    end

    always_comb begin
        state_d          = state_q;
        cause_d          = cause_q;
        pc_d             = pc_q;
        tval_d           = tval_q;
        mstatus_d        = mstatus_q;
        redirect_valid_d = 1'b0;
        redirect_pc_d    = redirect_pc_q;
        wen_c            = 1'b0;
        addr_c           = bus.pipe_csr_addr;
        wdata_c          = bus.pipe_csr_wdata;
        unique case (state_q)
            IDLE: begin
                wen_c = bus.pipe_csr_wen;
                // No new sequence may start while the previous redirect is on the bus.
                if (!redirect_valid_q) begin
                    if (bus.trap_req) begin
                        wen_c   = 1'b0;
                        cause_d = bus.trap_cause;
                        pc_d    = bus.trap_pc;
                        tval_d  = bus.trap_tval;
                        state_d = T_EPC;
                    end else if (bus.mret_req) begin
                        wen_c   = 1'b0;
                        state_d = M_SRD;
                    end
                end
            end
            T_EPC: begin
                wen_c   = 1'b1;
                addr_c  = ADDR_MEPC;
                wdata_c = {pc_q[WORD_LENGTH-1:2], 2'b00};
                state_d = T_CAUSE;
            end
            T_CAUSE: begin
                wen_c   = 1'b1;
                addr_c  = ADDR_MCAUSE;
                wdata_c = cause_q;
                state_d = T_TVAL;
            end
            T_TVAL: begin
                wen_c   = 1'b1;
                addr_c  = ADDR_MTVAL;
                wdata_c = tval_q;
                state_d = T_SRD;
            end
            T_SRD: begin
                addr_c    = ADDR_MSTATUS;
                wdata_c   = '0;
                mstatus_d = bus.csr_rdata;
                state_d   = T_SWR;
            end
            T_SWR: begin
                wen_c   = 1'b1;
                addr_c  = ADDR_MSTATUS;
                wdata_c = mstatus_trap;
                state_d = T_VEC;
            end
            T_VEC: begin
                addr_c           = ADDR_MTVEC;
                wdata_c          = '0;
                redirect_valid_d = 1'b1;
                if (bus.csr_rdata[1:0] == 2'b01 && cause_q[WORD_LENGTH-1])
                    redirect_pc_d = vec_base + vec_off;
                else
                    redirect_pc_d = vec_base;
                state_d = IDLE;
            end
            M_SRD: begin
                addr_c    = ADDR_MSTATUS;
                wdata_c   = '0;
                mstatus_d = bus.csr_rdata;
                state_d   = M_SWR;
            end
            M_SWR: begin
                wen_c   = 1'b1;
                addr_c  = ADDR_MSTATUS;
                wdata_c = mstatus_mret;
                state_d = M_EPC;
            end
            M_EPC: begin
                addr_c           = ADDR_MEPC;
                wdata_c          = '0;
                redirect_valid_d = 1'b1;
                redirect_pc_d    = {bus.csr_rdata[WORD_LENGTH-1:2], 2'b00};
                state_d          = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= IDLE;
            cause_q          <= '0;
            pc_q             <= '0;
            tval_q           <= '0;
            mstatus_q        <= '0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
        end else begin
            state_q          <= state_d;
            cause_q          <= cause_d;
            pc_q             <= pc_d;
            tval_q           <= tval_d;
            mstatus_q        <= mstatus_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
        end
    end

    // Write enable is gated by reset so a held reset can never commit a CSR write.
    assign bus.csr_wen        = rst_n & wen_c;
    assign bus.csr_addr       = addr_c;
    assign bus.csr_wdata      = wdata_c;
    assign bus.busy           = (state_q != IDLE);
    assign bus.redirect_valid = redirect_valid_q;
    assign bus.redirect_pc    = redirect_pc_q;
    assign bus.dbg_state      = state_q;
endmodule
